// File: rtl/transmisor_sincronia_pkg.sv
// transmisor_sincronia_pkg: shared states, default widths and patterns for the sync-framing transmitter
package transmisor_sincronia_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, FIN} estado_t;
  localparam int W_DEF = 5;
  localparam logic [W_DEF-1:0] SECUENCIA_DEF = 5'b10100;
  localparam logic [W_DEF-1:0] SEC_REINICIO_DEF = 5'b00000;
  localparam int CW_DEF = $clog2(W_DEF);
endpackage

// File: rtl/transmisor_sincronia_serializador.sv
// transmisor_sincronia_serializador: W-bit parallel-load MSB-first shift register with bit counter and word-boundary flag
module transmisor_sincronia_serializador
  import transmisor_sincronia_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cargar,
  input  logic         i_limpiar,
  input  logic         i_activo,
  input  logic [W-1:0] i_palabra,
  output logic         o_bit,
  output logic         o_frontera
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  logic [W-1:0] r_reg;
  logic [CW-1:0] r_cnt;
  // Load restarts the count at the word MSB; otherwise shift one bit per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || i_limpiar) begin
      r_reg <= '0;
      r_cnt <= '0;
    end else if (i_cargar) begin
      r_reg <= i_palabra;
      r_cnt <= '0;
    end else if (i_activo) begin
      r_reg <= {r_reg[W-2:0], 1'b0};
      r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_bit = r_reg[W-1];
  assign o_frontera = r_cnt == CW'(W - 1);
endmodule

// File: rtl/transmisor_sincronia.sv
// transmisor_sincronia: serial framing transmitter (sync pattern, data words, sync-loss pattern); define TRANSMISOR_RELLENO_EN to fill underruns with SECUENCIA instead of closing the link
module transmisor_sincronia
  import transmisor_sincronia_pkg::*;
#(
  parameter int W = W_DEF,
  parameter logic [W-1:0] SECUENCIA = W'(SECUENCIA_DEF),
  parameter logic [W-1:0] SEC_REINICIO = W'(SEC_REINICIO_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_iniciar,
  input  logic         i_detener,
  input  logic [W-1:0] i_dato,
  input  logic         i_dato_valido,
  output logic         o_dato_listo,
  output logic         o_s_out,
  output logic         o_en_linea,
  output logic         o_descartado
);
  estado_t r_estado, w_estado_sig;
  logic r_stop_p, w_stop_sig, r_descartado, w_descartado;
  logic w_cargar, w_limpiar, w_activo, w_frontera;
  logic [W-1:0] w_palabra;
  logic w_transmite, w_parar;
  assign w_transmite = (r_estado == SYNC) || (r_estado == DATA);
  assign w_parar = r_stop_p | i_detener;
  assign o_dato_listo = w_transmite & w_frontera & ~w_parar;
  assign o_en_linea = (r_estado == DATA) || (r_estado == FIN);
  assign o_descartado = r_descartado;
  transmisor_sincronia_serializador #(.W(W)) u_serializador (
    .clk       (clk),
    .rst       (rst),
    .i_cargar  (w_cargar),
    .i_limpiar (w_limpiar),
    .i_activo  (w_activo),
    .i_palabra (w_palabra),
    .o_bit     (o_s_out),
    .o_frontera(w_frontera)
  );
  // Next state, serializer control and stop/drop bookkeeping; boundaries pick the next word to load.
  always_comb begin
    w_estado_sig = r_estado;
    w_stop_sig = r_stop_p;
    w_cargar = 1'b0;
    w_limpiar = 1'b0;
    w_activo = 1'b0;
    w_palabra = SEC_REINICIO;
    w_descartado = 1'b0;
    case (r_estado)
      IDLE: begin
        if (i_iniciar) begin
          w_estado_sig = SYNC;
          w_cargar = 1'b1;
          w_palabra = SECUENCIA;
          w_stop_sig = i_detener;
        end
      end
      SYNC, DATA: begin
        if (w_frontera) begin
          w_cargar = 1'b1;
          w_stop_sig = 1'b0;
          if (w_parar) w_estado_sig = FIN;
          else if (i_dato_valido && i_dato != SEC_REINICIO) begin
            w_palabra = i_dato;
            w_estado_sig = DATA;
          end else begin
            w_descartado = i_dato_valido;
`ifdef TRANSMISOR_RELLENO_EN
            w_palabra = SECUENCIA;
            w_estado_sig = DATA;
`else
            w_estado_sig = FIN;
`endif
          end
        end else begin
          w_activo = 1'b1;
          w_stop_sig = w_parar;
        end
      end
      FIN: begin
        if (w_frontera) begin
          w_limpiar = 1'b1;
          w_estado_sig = IDLE;
        end else w_activo = 1'b1;
      end
      default: w_estado_sig = IDLE;
    endcase
  end
  // State, pending-stop flag and registered drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= IDLE;
      r_stop_p <= 1'b0;
      r_descartado <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_stop_p <= w_stop_sig;
      r_descartado <= w_descartado;
    end
  end
endmodule

// File: tb/tb_transmisor_sincronia.sv
// tb_transmisor_sincronia: table vectors, directed corner sequences and random traffic against a bit-queue model
module tb_transmisor_sincronia;
  import transmisor_sincronia_pkg::*;
  localparam int W = W_DEF;
  localparam logic [W-1:0] SEC = SECUENCIA_DEF;
  localparam logic [W-1:0] REI = SEC_REINICIO_DEF;
`ifdef TRANSMISOR_RELLENO_EN
  localparam logic [W-1:0] TRAS_HUECO = SEC;
`else
  localparam logic [W-1:0] TRAS_HUECO = REI;
`endif
  logic clk = 0, rst = 1;
  logic i_iniciar = 0, i_detener = 0, i_dato_valido = 0;
  logic [W-1:0] i_dato = '0;
  logic o_dato_listo, o_s_out, o_en_linea, o_descartado;
  int n_chk = 0, n_fail = 0;
  int m_modo = 0;
  logic m_q[$];
  logic m_stop = 0, m_desc = 0, ult_listo = 0;
  typedef struct {logic ini, det, val; logic [W-1:0] d; logic listo, s, en;} vec_t;
  vec_t tab[17];
  logic [W-1:0] pal[3];
  logic [14:0] bits;
  int cnt;
  transmisor_sincronia dut (
    .clk(clk), .rst(rst), .i_iniciar(i_iniciar), .i_detener(i_detener),
    .i_dato(i_dato), .i_dato_valido(i_dato_valido), .o_dato_listo(o_dato_listo),
    .o_s_out(o_s_out), .o_en_linea(o_en_linea), .o_descartado(o_descartado)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nom, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nom, $time, act, exp);
    end
  endtask
  task automatic chk_int(input string nom, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nom, act, exp);
    end
  endtask
  task automatic poner(input logic [W-1:0] w);
    for (int b = W - 1; b >= 0; b--) m_q.push_back(w[b]);
  endtask
  // Reference: frames are queues of bits; a boundary is the last queued bit being on the line.
  task automatic modelo(input logic ini, det, val, input logic [W-1:0] d);
    m_desc = 0;
    if (m_modo == 0) begin
      if (ini) begin
        m_q.delete();
        poner(SEC);
        m_modo = 1;
        m_stop = det;
      end
    end else if (m_q.size() > 1) begin
      void'(m_q.pop_front());
      if (det && m_modo != 3) m_stop = 1;
    end else begin
      void'(m_q.pop_front());
      if (m_modo == 3) m_modo = 0;
      else if (m_stop || det) begin
        poner(REI);
        m_modo = 3;
        m_stop = 0;
      end else if (val && d != REI) begin
        poner(d);
        m_modo = 2;
      end else begin
        m_desc = val;
        poner(TRAS_HUECO);
        m_modo = (TRAS_HUECO == SEC) ? 2 : 3;
      end
    end
  endtask
  task automatic ciclo(input logic ini, det, val, input logic [W-1:0] d);
    logic e_listo;
    i_iniciar = ini;
    i_detener = det;
    i_dato_valido = val;
    i_dato = d;
    @(negedge clk);
    e_listo = (m_modo == 1 || m_modo == 2) && m_q.size() == 1 && !m_stop && !det;
    chk("dato_listo", o_dato_listo, e_listo);
    ult_listo = o_dato_listo;
    @(posedge clk);
    modelo(ini, det, val, d);
    #1;
    chk("s_out", o_s_out, (m_modo != 0 && m_q.size() > 0) ? m_q[0] : 1'b0);
    chk("en_linea", o_en_linea, m_modo >= 2);
    chk("descartado", o_descartado, m_desc);
  endtask
  task automatic reiniciar();
    i_iniciar = 0;
    i_detener = 0;
    i_dato_valido = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst s_out", o_s_out, 1'b0);
    chk("rst en_linea", o_en_linea, 1'b0);
    chk("rst dato_listo", o_dato_listo, 1'b0);
    chk("rst descartado", o_descartado, 1'b0);
    rst = 0;
    m_modo = 0;
    m_q.delete();
    m_stop = 0;
    m_desc = 0;
  endtask
  task automatic esperar(input int n, input logic val, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) ciclo(0, 0, val, d);
  endtask
  initial begin
    tab[0] = '{1, 0, 0, 5'b00000, 0, 1, 0};
    tab[1] = '{0, 0, 0, 5'b00000, 0, 0, 0};
    tab[2] = '{0, 0, 0, 5'b00000, 0, 1, 0};
    tab[3] = '{0, 0, 0, 5'b00000, 0, 0, 0};
    tab[4] = '{0, 0, 0, 5'b00000, 0, 0, 0};
    tab[5] = '{0, 0, 1, 5'b11001, 1, 1, 1};
    tab[6] = '{0, 1, 0, 5'b00000, 0, 1, 1};
    tab[7] = '{0, 0, 0, 5'b00000, 0, 0, 1};
    tab[8] = '{0, 0, 0, 5'b00000, 0, 0, 1};
    tab[9] = '{0, 0, 0, 5'b00000, 0, 1, 1};
    for (int i = 10; i < 15; i++) tab[i] = '{0, 0, 0, 5'b00000, 0, 0, 1};
    for (int i = 15; i < 17; i++) tab[i] = '{0, 0, 0, 5'b00000, 0, 0, 0};
    pal[0] = 5'b11011;
    pal[1] = 5'b01110;
    pal[2] = 5'b10001;
    reiniciar();
    esperar(3, 0, '0);
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      ciclo(tab[i].ini, tab[i].det, tab[i].val, tab[i].d);
      chk("tab listo", ult_listo, tab[i].listo);
      chk("tab s_out", o_s_out, tab[i].s);
      chk("tab en_linea", o_en_linea, tab[i].en);
      cnt += int'(o_en_linea);
    end
    chk_int("en_linea cycles", cnt, 10);
    ciclo(1, 0, 0, '0);
    esperar(4, 0, '0);
    cnt = 0;
    bits = '0;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < W; i++) begin
        ciclo(0, 0, 1, pal[w]);
        cnt += int'(ult_listo);
        bits = {bits[13:0], o_s_out};
      end
    chk_int("b2b listo count", cnt, 3);
    chk_int("b2b bits", int'(bits), int'(15'b110110111010001));
    ciclo(0, 1, 1, pal[0]);
    esperar(6, 0, '0);
    ciclo(1, 0, 0, '0);
    esperar(4, 0, '0);
    ciclo(0, 0, 1, REI);
    cnt = int'(o_descartado);
    bits = {10'd0, o_s_out, 4'd0};
    for (int i = 0; i < 4; i++) begin
      ciclo(0, 0, 0, '0);
      cnt += int'(o_descartado);
      bits[3 - i] = o_s_out;
    end
    chk_int("forbidden descartado", cnt, 1);
    chk_int("forbidden follow", int'(bits[4:0]), int'(TRAS_HUECO));
    ciclo(0, 1, 0, '0);
    esperar(12, 0, '0);
    reiniciar();
    ciclo(1, 0, 0, '0);
    esperar(4, 0, '0);
    ciclo(0, 0, 1, 5'b11001);
    esperar(4, 0, '0);
    bits = '0;
    for (int i = 0; i < W; i++) begin
      ciclo(0, 0, 0, '0);
      bits = {bits[13:0], o_s_out};
      chk("underrun en_linea", o_en_linea, 1'b1);
    end
    chk_int("underrun word", int'(bits[4:0]), int'(TRAS_HUECO));
    ciclo(0, 1, 0, '0);
    esperar(12, 0, '0);
    ciclo(1, 1, 1, 5'b11001);
    cnt = 0;
    bits = {14'd0, o_s_out};
    for (int i = 0; i < 11; i++) begin
      ciclo(0, 0, 1, 5'b11001);
      cnt += int'(ult_listo);
      if (i < 9) bits = {bits[13:0], o_s_out};
    end
    chk_int("ini+det listo", cnt, 0);
    chk_int("ini+det bits", int'(bits[9:0]), int'(10'b1010000000));
    ciclo(1, 0, 0, '0);
    esperar(4, 0, '0);
    ciclo(0, 0, 1, 5'b10110);
    ciclo(1, 0, 0, '0);
    ciclo(0, 0, 0, '0);
    ciclo(1, 0, 0, '0);
    ciclo(0, 0, 0, '0);
    ciclo(1, 0, 1, 5'b01011);
    ciclo(1, 0, 0, '0);
    esperar(2, 0, '0);
    reiniciar();
    for (int i = 0; i < 6; i++) begin
      ciclo(0, 0, 0, '0);
      chk("idle after rst", o_s_out, 1'b0);
    end
    for (int i = 0; i < 3000; i++)
      ciclo($urandom_range(7) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
            ($urandom_range(5) == 0) ? REI : W'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
